// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin front end for a shared, combinational ALU.
// A granted request drives registered operands to the ALU, waits WAIT_CYC
// cycles for the result to settle, captures it and holds it as a response
// until the consumer takes it. One operation is in flight at a time.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. Requesters keep op/num1 stable while valid & !ready and may drop valid
// before acceptance without effect. req*_ready is only ever high in IDLE, for
// the arbitration winner, and does not depend on rsp_ready. rsp_valid stays
// high with stable rsp_id/rsp_result until rsp_ready is seen; rsp_ready
// outside RESP is ignored.
module alu_arb #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [7:0]  req0_num1,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [7:0]  req1_num1,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_num1,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter value on which the ALU result is sampled.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_num1_q, alu_num1_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        grant0, grant1;

    // Arbitration, next-state and datapath load decisions.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_num1_d   = alu_num1_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        grant0       = 1'b0;
        grant1       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A lone requester wins; on contention rr picks the winner.
                grant0 = req0_valid & (~req1_valid | ~rr_q);
                grant1 = req1_valid & (~req0_valid |  rr_q);
                if (grant0) begin
                    alu_op_d   = req0_op;
                    alu_num1_d = req0_num1;
                    rsp_id_d   = 1'b0;
                    rr_d       = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = S_EXEC;
                end else if (grant1) begin
                    alu_op_d   = req1_op;
                    alu_num1_d = req1_num1;
                    rsp_id_d   = 1'b1;
                    rr_d       = 1'b0;
                    cnt_d      = 4'd0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    rsp_result_d = alu_result;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_q         <= 1'b0;
            cnt_q        <= 4'd0;
            alu_op_q     <= 3'b000;
            alu_num1_q   <= 8'h00;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_num1_q   <= alu_num1_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    // Output mapping.
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        alu_op     = alu_op_q;
        alu_num1   = alu_num1_q;
        rsp_valid  = (state_q == S_RESP);
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
        busy       = (state_q != S_IDLE);
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed vectors for alu_arb with a stub ALU
// (result = {op, 21'b0, num1}). u_dut runs WAIT_CYC=1, u_dut4 runs WAIT_CYC=4.
module tb_alu_arb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- WAIT_CYC=1 instance ----------------
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic [7:0]  req0_num1 = 0, req1_num1 = 0;
    logic [2:0]  alu_op;
    logic [7:0]  alu_num1;
    logic [31:0] alu_result;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 0;
    logic [31:0] rsp_result;
    logic [1:0]  dbg_state;

    assign alu_result = {alu_op, 21'b0, alu_num1};

    alu_arb #(.WAIT_CYC(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_num1(req0_num1),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_num1(req1_num1),
        .alu_op(alu_op), .alu_num1(alu_num1), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- WAIT_CYC=4 instance ----------------
    logic        w_req1_valid = 0;
    logic        w_req0_ready, w_req1_ready;
    logic [2:0]  w_req1_op = 0;
    logic [7:0]  w_req1_num1 = 0;
    logic [2:0]  w_alu_op;
    logic [7:0]  w_alu_num1;
    logic [31:0] w_alu_result;
    logic        w_rsp_valid, w_rsp_id, w_busy;
    logic        w_rsp_ready = 0;
    logic [31:0] w_rsp_result;
    logic [1:0]  w_dbg_state;

    assign w_alu_result = {w_alu_op, 21'b0, w_alu_num1};

    alu_arb #(.WAIT_CYC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(1'b0), .req0_ready(w_req0_ready),
        .req0_op(3'b000), .req0_num1(8'h00),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready),
        .req1_op(w_req1_op), .req1_num1(w_req1_num1),
        .alu_op(w_alu_op), .alu_num1(w_alu_num1), .alu_result(w_alu_result),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
        .rsp_id(w_rsp_id), .rsp_result(w_rsp_result),
        .busy(w_busy), .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic        exp_id_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for a response on u_dut; compares against the queue heads.
    task automatic wait_rsp(input string tag);
        logic [31:0] e;
        logic        eid;
        bit          seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            eid = exp_id_q.pop_front();
            check({tag, "_result"}, rsp_result, e);
            check({tag, "_id"}, 32'(rsp_id), 32'(eid));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   lat;
        bit   leaked;
        logic [2:0] c_op  [2];
        logic [7:0] c_num [2];
        int   order [3];

        // Reset asserted mid-cycle, before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_alu_op",     32'(alu_op), 32'd0);
        check("rst_alu_num1",   32'(alu_num1), 32'h00);
        check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
        check("rst_rsp_id",     32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_readies",    32'({req0_ready, req1_ready}), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single op from req0.
        req0_op = 3'b010; req0_num1 = 8'hFE; req0_valid = 1; rsp_ready = 1;
        #1;
        check("single_r0_ready", 32'(req0_ready), 32'd1);
        check("single_r1_ready", 32'(req1_ready), 32'd0);
        tick();                               // accept edge
        req0_valid = 0;
        check("single_busy",  32'(busy), 32'd1);
        check("single_alu",   32'({alu_op, alu_num1}), 32'({3'b010, 8'hFE}));
        check("single_nrdy",  32'(req0_ready), 32'd0);
        tick();                               // one cycle after accept
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_result", rsp_result, 32'h4000_00FE);
        check("single_id",    32'(rsp_id), 32'd0);
        tick();                               // handshake edge
        check("single_idle_valid", 32'(rsp_valid), 32'd0);
        check("single_idle_busy",  32'(busy), 32'd0);

        // Contention with both requesters continuously valid.
        do_reset();
        c_op[0] = 3'b001; c_num[0] = 8'hFF;
        c_op[1] = 3'b101; c_num[1] = 8'h81;
        order[0] = 0; order[1] = 1; order[2] = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({c_op[order[i]], 21'b0, c_num[order[i]]});
            exp_id_q.push_back(order[i][0]);
        end
        check("cont_exp0", exp_q[1], 32'hA000_0081);
        req0_op = c_op[0]; req0_num1 = c_num[0];
        req1_op = c_op[1]; req1_num1 = c_num[1];
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        #1;
        check("cont_first_grant", 32'({req0_ready, req1_ready}), 32'b10);
        for (int i = 0; i < 3; i++) begin
            wait_rsp($sformatf("cont%0d", i));
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();

        // Backpressure: rr now points at req1.
        rsp_ready = 0;
        req1_op = 3'b110; req1_num1 = 8'h33; req1_valid = 1;
        tick();                               // accept
        req1_valid = 0;
        tick();                               // now in RESP
        req0_valid = 1; req1_valid = 1; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid",  32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, 32'hC000_0033);
            check("bp_id",     32'(rsp_id), 32'd1);
            check("bp_alu",    32'({alu_op, alu_num1}), 32'({3'b110, 8'h33}));
            check("bp_ready",  32'({req0_ready, req1_ready}), 32'd0);
            check("bp_busy",   32'(busy), 32'd1);
            tick();
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        tick();
        check("bp_release", 32'(rsp_valid), 32'd0);
        tick();

        // Reset during EXEC aborts the op.
        do_reset();
        req0_op = 3'b011; req0_num1 = 8'hAA; req0_valid = 1; rsp_ready = 1;
        tick();                               // accept -> EXEC
        req0_valid = 0;
        check("abort_in_exec", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_alu",   32'({alu_op, alu_num1}), 32'd0);
        leaked = 0;
        tick();
        leaked |= rsp_valid;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            leaked |= rsp_valid;
        end
        check("abort_no_rsp", 32'(leaked), 32'd0);
        exp_q.push_back(32'h8000_00F0);
        exp_id_q.push_back(1'b1);
        req1_op = 3'b100; req1_num1 = 8'hF0; req1_valid = 1;
        tick();                               // accept
        req1_valid = 0;
        // wait_rsp ticks first; step back one cycle in bookkeeping by waiting here.
        check("post_abort_busy", 32'(busy), 32'd1);
        wait_rsp("post_abort");
        tick();

        // Long wait on the WAIT_CYC=4 instance.
        w_req1_op = 3'b000; w_req1_num1 = 8'h02; w_req1_valid = 1; w_rsp_ready = 1;
        #1;
        check("long_ready", 32'(w_req1_ready), 32'd1);
        tick();                               // accept edge
        w_req1_valid = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (w_rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("long_latency", 32'(lat), 32'd4);
        check("long_result",  w_rsp_result, 32'h0000_0002);
        check("long_id",      32'(w_rsp_id), 32'd1);
        tick();
        check("long_idle", 32'(w_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
